// File: rtl/flash_ctrl_pkg.sv
// Shared constants, state encoding and phase helpers for the quad-SPI flash read controller.
package flash_ctrl_pkg;

    localparam logic [7:0] OPC_QUAD_READ = 8'hEB;
    localparam logic [7:0] MODE_BYTE     = 8'h00;

    localparam int LEN_CMD   = 8;
    localparam int LEN_ADDR  = 6;
    localparam int LEN_MODE  = 2;
    localparam int LEN_DUMMY = 4;
    localparam int LEN_DATA  = 8;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE} state_t;

    function automatic state_t next_phase(state_t s);
        case (s)
            CMD:     return ADDR;
            ADDR:    return MODE;
            MODE:    return DUMMY;
            DUMMY:   return DATA;
            default: return DONE;
        endcase
    endfunction

    // Period down-counter load value; terminal count is zero.
    function automatic logic [2:0] phase_load(state_t s);
        case (s)
            CMD:     return 3'(LEN_CMD - 1);
            ADDR:    return 3'(LEN_ADDR - 1);
            MODE:    return 3'(LEN_MODE - 1);
            DUMMY:   return 3'(LEN_DUMMY - 1);
            DATA:    return 3'(LEN_DATA - 1);
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/qspi_read_engine.sv
// Runs one Quad I/O Read (0xEB) transaction in SPI mode 0, sck = clk/2, and returns a little-endian word.
//
// state | meaning
// IDLE  | ce_n high, waiting for start
// CMD   | opcode 0xEB on SIO0, WP#/HOLD# held high
// ADDR  | 24-bit address, one nibble per sck period
// MODE  | mode byte 0x00 (no continuous read)
// DUMMY | bus released, flash turnaround
// DATA  | 8 nibbles captured from din
// DONE  | ce_n high, word presented with done
module qspi_read_engine
    import flash_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] addr,
    output logic        done,
    output logic [31:0] word,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  dout,
    output logic [3:0]  douten,
    input  logic [3:0]  din
);

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        half, half_nx;
    logic [39:0] tx, tx_nx;
    logic [31:0] rx, rx_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
            half  <= 1'b0;
            tx    <= '0;
            rx    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            half  <= half_nx;
            tx    <= tx_nx;
            rx    <= rx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        half_nx  = 1'b0;
        tx_nx    = tx;
        rx_nx    = rx;
        ce_n     = 1'b1;
        dout     = 4'h0;
        douten   = 4'h0;
        done     = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    state_nx = CMD;
                    cnt_nx   = phase_load(CMD);
                    tx_nx    = {OPC_QUAD_READ, addr, MODE_BYTE};
                end else begin
                    state_nx = IDLE;
                end
            end
            default: begin
                ce_n    = 1'b0;
                half_nx = ~half;
                case (state)
                    CMD: begin
                        douten = 4'b1101;
                        dout   = {2'b11, 1'b0, tx[39]};
                    end
                    ADDR, MODE: begin
                        douten = 4'hF;
                        dout   = tx[39:36];
                    end
                    default: ;
                endcase
                // End of the high half: sck falls on this edge.
                if (half) begin
                    case (state)
                        CMD:        tx_nx = {tx[38:0], 1'b0};
                        ADDR, MODE: tx_nx = {tx[35:0], 4'h0};
                        DATA:       rx_nx = {rx[27:0], din};
                        default: ;
                    endcase
                    if (cnt == 3'd0) begin
                        state_nx = next_phase(state);
                        cnt_nx   = phase_load(next_phase(state));
                    end else begin
                        cnt_nx = cnt - 3'd1;
                    end
                end
            end
        endcase
    end

    assign sck  = half;
    assign word = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};

endmodule

// File: rtl/ahb_qspi_flash_ctrl.sv
// Read-only AHB-Lite slave: each read fetches one aligned word from quad-SPI NOR flash.
module ahb_qspi_flash_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int AW = 24
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HADDR,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        sck,
    output logic        ce_n,
    output logic [3:0]  dout,
    output logic [3:0]  douten,
    input  logic [3:0]  din
);

    localparam logic [31:0] ADDR_MASK = (AW >= 32) ? 32'hFFFF_FFFC
                                      : (((32'd1 << AW) - 32'd1) & 32'hFFFF_FFFC);

    logic        accept;
    logic        done;
    logic [31:0] word;
    logic [31:0] word_addr;
    logic        unused_ok;

    assign accept    = HSEL & HREADY & HTRANS[1] & ~HWRITE;
    assign word_addr = HADDR & ADDR_MASK;
    assign unused_ok = ^{HSIZE, HWDATA, word_addr[31:24]};

    qspi_read_engine u_engine (
        .clk    (HCLK),
        .rst_n  (HRESETn),
        .start  (accept),
        .addr   (word_addr[23:0]),
        .done   (done),
        .word   (word),
        .sck    (sck),
        .ce_n   (ce_n),
        .dout   (dout),
        .douten (douten),
        .din    (din)
    );

    // Word and ready are registered out of DONE, so the stall covers DONE as well.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HREADYOUT <= 1'b1;
            HRDATA    <= '0;
        end else begin
            if (done)
                HRDATA <= word;
            if (accept)
                HREADYOUT <= 1'b0;
            else if (done)
                HREADYOUT <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_qspi_flash_ctrl.sv
// Directed bench for ahb_qspi_flash_ctrl with a behavioural quad-SPI flash holding six words.
module tb_ahb_qspi_flash_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    wire         HREADY;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        sck, ce_n;
    logic [3:0]  dout, douten;
    logic [3:0]  din;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_qspi_flash_ctrl #(.AW(24)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HADDR(HADDR),
        .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
        .sck(sck), .ce_n(ce_n), .dout(dout), .douten(douten), .din(din)
    );

    // Flash model: words 0xAAAAAA00 .. 0xFFFFFF05 stored little-endian.
    logic [7:0]  mem [0:255];
    int          edge_cnt;
    logic [7:0]  cmd_seen;
    logic [23:0] addr_seen;
    logic [3:0]  oe_at [0:31];
    logic [3:0]  do_at [0:31];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int w = 0; w < 6; w++) begin
            mem[4*w]     = 8'(w);
            mem[4*w + 1] = 8'(8'hAA + 8'h11 * w);
            mem[4*w + 2] = 8'(8'hAA + 8'h11 * w);
            mem[4*w + 3] = 8'(8'hAA + 8'h11 * w);
        end
        din = 4'h0;
    end

    always @(negedge ce_n) begin
        edge_cnt  = 0;
        cmd_seen  = 8'h00;
        addr_seen = 24'h0;
    end

    always @(posedge sck) begin
        if (!ce_n) begin
            edge_cnt++;
            if (edge_cnt < 32) begin
                oe_at[edge_cnt] = douten;
                do_at[edge_cnt] = dout;
            end
            if (edge_cnt <= 8)
                cmd_seen = {cmd_seen[6:0], dout[0]};
            else if (edge_cnt <= 14)
                addr_seen = {addr_seen[19:0], dout};
            if (edge_cnt >= 21 && edge_cnt <= 28) begin
                automatic int j = edge_cnt - 21;
                automatic logic [7:0] b = mem[8'(addr_seen[7:0] + 8'(j / 2))];
                din = (j % 2 == 0) ? b[7:4] : b[3:0];
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge with HREADYOUT high; returns at the first negedge with HREADYOUT high again.
    task automatic do_read(input logic [31:0] a, input logic [2:0] sz,
                           output logic [31:0] data, output int low, output logic [5:0] first);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a; HSIZE = sz;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        low = 0;
        first = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK);
            if (i == 0) first = {ce_n, sck, dout};
            if (HREADYOUT) break;
            low++;
        end
        data = HRDATA;
    endtask

    logic [31:0] rd;
    int          low;
    logic [5:0]  first;
    int          bad;

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'd2; HADDR = '0; HWDATA = '0;
        repeat (3) @(negedge HCLK);
        chk("rst_ctrl", {21'd0, HREADYOUT, sck, ce_n, dout, douten}, {21'd0, 1'b1, 1'b0, 1'b1, 8'h00});
        chk("rst_hrdata", HRDATA, 32'h0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        do_read(32'h4, 3'd2, rd, low, first);
        chk("rd4_data", rd, 32'hBBBBBB01);
        chk("rd4_cmd", {24'd0, cmd_seen}, 32'h000000EB);
        chk("rd4_addr", {8'd0, addr_seen}, 32'h00000004);
        chk("rd4_low", 32'(low), 32'd57);
        chk("rd4_first", {26'd0, first}, {26'd0, 6'b00_1101});
        chk("rd4_ce_after", {31'd0, ce_n}, 32'd1);
        chk("oe_cmd", {24'd0, oe_at[1], do_at[1][3:2], 2'b00}, {24'd0, 4'b1101, 2'b11, 2'b00});
        chk("oe_addr", {28'd0, oe_at[9]}, 32'hF);
        chk("oe_mode", {24'd0, oe_at[15], do_at[16]}, {24'd0, 4'hF, 4'h0});
        chk("oe_dummy", {28'd0, oe_at[17]}, 32'h0);
        chk("oe_data", {28'd0, oe_at[25]}, 32'h0);

        do_read(32'h0, 3'd2, rd, low, first);
        chk("rd0_data", rd, 32'hAAAAAA00);
        do_read(32'hC, 3'd2, rd, low, first);
        chk("rdC_data", rd, 32'hDDDDDD03);
        do_read(32'h14, 3'd2, rd, low, first);
        chk("rd14_data", rd, 32'hFFFFFF05);

        do_read(32'h5, 3'd0, rd, low, first);
        chk("byte5_data", rd, 32'hBBBBBB01);
        chk("byte5_addr", {8'd0, addr_seen}, 32'h00000004);

        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge HCLK);
            if (!HREADYOUT || !ce_n) bad++;
        end
        chk("wr_quiet", 32'(bad), 32'd0);
        do_read(32'h0, 3'd2, rd, low, first);
        chk("wr_then_rd0", rd, 32'hAAAAAA00);

        do_read(32'h0, 3'd2, rd, low, first);
        chk("b2b_first", rd, 32'hAAAAAA00);
        chk("b2b_ce_gap", {31'd0, ce_n}, 32'd1);
        do_read(32'h4, 3'd2, rd, low, first);
        chk("b2b_second", rd, 32'hBBBBBB01);
        chk("b2b_low", 32'(low), 32'd57);

        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h8; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        repeat (48) @(negedge HCLK);
        chk("mid_busy", {30'd0, ce_n, HREADYOUT}, 32'd0);
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_ctrl", {21'd0, HREADYOUT, sck, ce_n, dout, douten}, {21'd0, 1'b1, 1'b0, 1'b1, 8'h00});
        chk("mid_rst_hrdata", HRDATA, 32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        do_read(32'hC, 3'd2, rd, low, first);
        chk("post_rst_rdC", rd, 32'hDDDDDD03);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
